lsu_subword: RTL

- Load/store unit sitting directly upstream of the word-wide data memory. The data memory exposes a 14-bit byte address, word-granular writes and an asynchronous read.
- Accepts RV32I load/store requests from the execute stage: LB/LH/LW/LBU/LHU/SB/SH/SW.
- Checks alignment and address range, and formats load data (byte/half extract, sign/zero extend).
- Implements SB/SH as a two-cycle read-modify-write, because the memory only supports full-word writes.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_subword_if.sv | 36 +++
 rtl/lsu_load_align.sv | 36 +++
 rtl/lsu_subword.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit slice.
//   - RV32I load/store funct3 encodings
//   - lsu_state_t: LSU control FSM states
//   - f3_legal(): funct3 legality check for loads and stores
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        ACCESS,
        MERGE,
        RESP,
        ERR
    } lsu_state_t;

    // Stores only have signed-size encodings; loads add the unsigned variants.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        else
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_subword_if.sv
// lsu_subword_if: request/response and data-memory bus of the LSU.
//   Request side : i_req, i_we, i_funct3, i_addr, i_wdata (execute stage -> LSU)
//   Response side: o_ready, o_done, o_err, o_rdata       (LSU -> execute stage)
//   Memory side  : o_mem_enb, o_mem_wren, o_mem_addr, o_mem_wdata (LSU -> memory),
//                  i_mem_rdata (memory -> LSU, combinational from o_mem_addr)
// Modports: slave = the LSU, master = execute stage plus data memory.
interface lsu_subword_if #(
    parameter int unsigned ADDR_W = 14
);
    logic              i_req;
    logic              i_we;
    logic [2:0]        i_funct3;
    logic [31:0]       i_addr;
    logic [31:0]       i_wdata;
    logic              o_ready;
    logic              o_done;
    logic              o_err;
    logic [31:0]       o_rdata;
    logic              o_mem_enb;
    logic              o_mem_wren;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic [31:0]       i_mem_rdata;

    modport slave (
        input  i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_rdata,
        output o_ready, o_done, o_err, o_rdata,
               o_mem_enb, o_mem_wren, o_mem_addr, o_mem_wdata
    );

    modport master (
        output i_req, i_we, i_funct3, i_addr, i_wdata, i_mem_rdata,
        input  o_ready, o_done, o_err, o_rdata,
               o_mem_enb, o_mem_wren, o_mem_addr, o_mem_wdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// lsu_load_align: combinational load formatter.
//   i_word   : 32-bit memory word
//   i_addr   : byte offset within the word
//   i_funct3 : RV32I load funct3 (B/H/W/BU/HU)
//   o_data   : selected byte/half/word, sign- or zero-extended
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        case (i_addr)
            2'd0:    lane_b = i_word[7:0];
            2'd1:    lane_b = i_word[15:8];
            2'd2:    lane_b = i_word[23:16];
            default: lane_b = i_word[31:24];
        endcase
        lane_h = i_addr[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        case (i_funct3)
            F3_B:    o_data = {{24{lane_b[7]}}, lane_b};
            F3_BU:   o_data = {24'h0, lane_b};
            F3_H:    o_data = {{16{lane_h[15]}}, lane_h};
            F3_HU:   o_data = {16'h0, lane_h};
            default: o_data = i_word;
        endcase
    end
endmodule

// File: rtl/lsu_subword.sv
// lsu_subword: RV32I load/store unit in front of a word-wide data memory.
//   i_clk, i_rst : clock (rising edge), asynchronous active-high reset
//   bus          : lsu_subword_if.slave -- request, response and memory ports
// Sub-word stores are a read (ACCESS) followed by a full-word write (MERGE).
// Build option: define LSU_MISALIGN_TRAP_EN to report misaligned half/word
// accesses as errors; otherwise the low address bits are masked and the
// access proceeds.
module lsu_subword
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W    = 14,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic          i_clk,
    input  logic          i_rst,
    lsu_subword_if.slave  bus
);
    lsu_state_t        state_q, state_d;
    logic              req_we_q;
    logic [2:0]        req_f3_q;
    logic [ADDR_W-1:0] req_addr_q;
    logic [31:0]       req_wdata_q;
    logic [31:0]       merge_q;
    logic [31:0]       rdata_q;

    logic              legal;
    logic              in_range;
    logic              misaligned;
    logic              req_bad;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       load_fmt;
    logic [31:0]       merged;
    logic              mem_enb;
    logic              mem_wren;
    logic [31:0]       mem_wdata;

    // ---------------- request decode (IDLE only) ----------------
    always_comb begin
        legal      = f3_legal(bus.i_we, bus.i_funct3);
        in_range   = (bus.i_addr[31:ADDR_W] == BASE_ADDR[31:ADDR_W]);
        misaligned = ((bus.i_funct3[1:0] == 2'b01) && bus.i_addr[0]) ||
                     ((bus.i_funct3[1:0] == 2'b10) && (bus.i_addr[1:0] != 2'b00));
        acc_addr   = bus.i_addr[ADDR_W-1:0];
`ifdef LSU_MISALIGN_TRAP_EN
        req_bad    = !legal || !in_range || misaligned;
`else
        // Misalignment is tolerated: drop the offending low bits so the
        // access lands on the enclosing naturally aligned half/word.
        req_bad    = !legal || !in_range;
        if (bus.i_funct3[1:0] == 2'b01) acc_addr[0]   = 1'b0;
        if (bus.i_funct3[1:0] == 2'b10) acc_addr[1:0] = 2'b00;
`endif
    end

    lsu_load_align u_align (
        .i_word   (bus.i_mem_rdata),
        .i_addr   (req_addr_q[1:0]),
        .i_funct3 (req_f3_q),
        .o_data   (load_fmt)
    );

    // Replace the addressed lane of the word read in ACCESS.
    always_comb begin
        merged = merge_q;
        if (req_f3_q == F3_H) begin
            if (req_addr_q[1]) merged[31:16] = req_wdata_q[15:0];
            else               merged[15:0]  = req_wdata_q[15:0];
        end else begin
            case (req_addr_q[1:0])
                2'd0:    merged[7:0]   = req_wdata_q[7:0];
                2'd1:    merged[15:8]  = req_wdata_q[7:0];
                2'd2:    merged[23:16] = req_wdata_q[7:0];
                default: merged[31:24] = req_wdata_q[7:0];
            endcase
        end
    end

    // ---------------- state and request registers ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            req_we_q    <= 1'b0;
            req_f3_q    <= '0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            merge_q     <= '0;
            rdata_q     <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && bus.i_req) begin
                req_we_q    <= bus.i_we;
                req_f3_q    <= bus.i_funct3;
                req_addr_q  <= acc_addr;
                req_wdata_q <= bus.i_wdata;
            end
            if (state_q == ACCESS) begin
                if (!req_we_q) rdata_q <= load_fmt;
                merge_q <= bus.i_mem_rdata;
            end
        end
    end

    // ---------------- next state and outputs ----------------
    always_comb begin
        state_d     = state_q;
        bus.o_ready = 1'b0;
        bus.o_done  = 1'b0;
        bus.o_err   = 1'b0;
        mem_enb     = 1'b0;
        mem_wren    = 1'b0;
        mem_wdata   = '0;
        case (state_q)
            IDLE: begin
                bus.o_ready = 1'b1;
                if (bus.i_req) state_d = req_bad ? ERR : ACCESS;
            end
            ACCESS: begin
                mem_enb = 1'b1;
                if (req_we_q && req_f3_q == F3_W) begin
                    mem_wren  = 1'b1;
                    mem_wdata = req_wdata_q;
                    state_d   = RESP;
                end else if (req_we_q) begin
                    state_d = MERGE;
                end else begin
                    state_d = RESP;
                end
            end
            MERGE: begin
                mem_enb   = 1'b1;
                mem_wren  = 1'b1;
                mem_wdata = merged;
                state_d   = RESP;
            end
            RESP: begin
                bus.o_done = 1'b1;
                state_d    = IDLE;
            end
            ERR: begin
                bus.o_done = 1'b1;
                bus.o_err  = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Address/data are held at zero while the memory is not enabled.
    assign bus.o_mem_enb   = mem_enb;
    assign bus.o_mem_wren  = mem_wren;
    assign bus.o_mem_wdata = mem_wdata;
    assign bus.o_mem_addr  = mem_enb ? {req_addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus.o_rdata     = (state_q == ERR) ? '0 : rdata_q;
endmodule
